mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one single-port data memory between NUM_CORES cores of the multi-core processor.
- Each core raises a request with address, write data and write enable.
- The arbiter grants one core at a time, drives the memory, waits a fixed memory latency, returns read data and pulses a per-core completion.
- Sits between the core load/store stages and the shared data memory.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter_rr_picker.sv | 33 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the multi-core data-memory arbiter: default widths
// (kept in step with the core top level), counter width and the FSM encoding.
package mem_arbiter_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_LAT   = 2;

  // Latency counter holds MEM_LAT-1, and MEM_LAT is at most 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of core-side request/response signals and memory-side strobes.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding system, which drives the core requests and the memory's
// read data.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) ();

  // Core side: flattened per-core fields, core i at [i*W +: W].
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;

  // Memory side: single-port data memory.
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker. It searches req starting at last+1 and
// wraps modulo NUM_CORES, so the previous winner gets the lowest priority.
module rr_picker #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  logic [IDX_W-1:0] cand;

  // The scan runs from lowest to highest priority. A later hit overwrites an
  // earlier one, so the candidate at last+1 wins when it is requesting.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment. Otherwise a path that skips the assignment
    // would infer a latch.
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_CORES);
      if (req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port data memory
// between NUM_CORES cores. One transaction runs at a time. The winning
// core's request is latched at grant. The FSM waits MEM_LAT cycles, returns
// read data and pulses a one-hot done. An IDLE bubble separates transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                 state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [IDX_W-1:0]       last_q,      last_d;
  logic [NUM_CORES-1:0]   gnt_q,       gnt_d;
  logic [NUM_CORES-1:0]   done_q,      done_d;
  logic [DATA_W-1:0]      rdata_q,     rdata_d;
  logic                   mem_en_q,    mem_en_d;
  logic                   mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req    (bus.req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;  // strobe lasts exactly one cycle per transaction
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // Latch the winner's request now. Later changes on its inputs are
          // ignored until the transaction completes.
          gnt_d       = NUM_CORES'(1) << pick_idx;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.we[pick_idx];
          mem_addr_d  = bus.addr[pick_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.wdata[pick_idx*DATA_W +: DATA_W];
          cnt_d       = CNT_W'(MEM_LAT - 1);
          last_d      = pick_idx;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = gnt_q;
          // A write leaves the broadcast read data untouched.
          if (!mem_we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d  = IDLE;
        gnt_d    = '0;
        done_d   = '0;
        mem_we_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. A synchronous reset aborts any transaction
  // in flight, and no done is issued for it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IDX_W'(NUM_CORES - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It uses a table of single
// transactions, hand-written multi-cycle sequences (reset, round-robin,
// early drop, reset mid-access), and a scoreboard that checks every done
// pulse against the expected core and read data.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NC      = 4;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int MEM_LAT = 2;

  logic clk;
  logic rst;

  mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: synchronous write, address-held asynchronous read.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] exp_mem [256];

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] onehot(input int i);
    logic [NC-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard of expected completions, in service order.
  typedef struct {
    int            core;
    logic [DW-1:0] rdata;
  } sb_t;

  sb_t           sb_q[$];
  logic [DW-1:0] last_rd = '0;

  task automatic push_exp(input int core, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    sb_t e;
    e.core = core;
    if (w) begin
      exp_mem[a] = d;
      e.rdata    = last_rd;
    end else begin
      e.rdata = exp_mem[a];
      last_rd = e.rdata;
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input int core, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.we[core]              = w;
    bus.addr[core*AW +: AW]   = a;
    bus.wdata[core*DW +: DW]  = d;
    bus.req[core]             = 1'b1;
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (bus.done !== '0) begin
      if (sb_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL sb_unexpected_done at %0t: got done=%0h, expected none", $time, bus.done);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_done_core", bus.done, onehot(e.core));
        check("sb_rdata", bus.rdata, e.rdata);
      end
    end
  end

  // Called at the sample just after the grant edge. Runs the transaction to
  // the IDLE cycle that follows DONE, checking cycle-exact strobes.
  task automatic finish_txn(input int core, input bit keep);
    check("gnt_at_grant", bus.gnt, onehot(core));
    check("mem_en_first", bus.mem_en, 1'b1);
    check("busy_access", bus.busy, 1'b1);
    for (int k = 0; k < MEM_LAT; k++) begin
      tick();
      check("mem_en_single", bus.mem_en, 1'b0);
      if (k < MEM_LAT - 1) check("done_not_early", bus.done, '0);
    end
    check("done_pulse", bus.done, onehot(core));
    check("gnt_in_done", bus.gnt, onehot(core));
    if (!keep) bus.req[core] = 1'b0;
    tick();
    check("done_cleared", bus.done, '0);
    check("gnt_cleared", bus.gnt, '0);
    check("busy_idle", bus.busy, 1'b0);
  endtask

  typedef struct {
    int            core;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = {24'hA5A5A5, 8'(i)};
      exp_mem[i] = {24'hA5A5A5, 8'(i)};
    end
    mem[8'h12]     = 32'hDEADBEEF;
    exp_mem[8'h12] = 32'hDEADBEEF;

    vecs[0] = '{2, 1'b0, 8'h12, 32'h0000_0000, 32'hDEADBEEF};
    vecs[1] = '{1, 1'b1, 8'h05, 32'h1111_1111, 32'hDEADBEEF};
    vecs[2] = '{0, 1'b0, 8'h05, 32'h0000_0000, 32'h1111_1111};
    vecs[3] = '{3, 1'b1, 8'hFF, 32'hCAFE_F00D, 32'h1111_1111};
    vecs[4] = '{3, 1'b0, 8'hFF, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[5] = '{1, 1'b0, 8'h00, 32'h0000_0000, 32'hA5A5_A500};

    // Reset held for two cycles with all cores requesting.
    rst       = 1'b1;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < NC; i++) drive(i, 1'b0, 8'(8'h20 + i), '0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_gnt", bus.gnt, '0);
      check("rst_done", bus.done, '0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_mem_en", bus.mem_en, 1'b0);
      check("rst_rdata", bus.rdata, '0);
    end

    // Round-robin: all four requests held, grant order 0,1,2,3,0.
    for (int n = 0; n < 5; n++) push_exp(n % NC, 1'b0, 8'(8'h20 + (n % NC)), '0);
    rst = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      if (n == 4) begin
        bus.req = '0;
        finish_txn(0, 1'b0);
      end else begin
        finish_txn(n, 1'b1);
        tick();
      end
    end

    // Table of single transactions.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].core, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      push_exp(vecs[i].core, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      tick();
      check("vec_mem_we", bus.mem_we, vecs[i].we);
      check("vec_mem_addr", bus.mem_addr, vecs[i].addr);
      if (vecs[i].we) check("vec_mem_wdata", bus.mem_wdata, vecs[i].wdata);
      finish_txn(vecs[i].core, 1'b0);
      check("vec_rdata", bus.rdata, vecs[i].exp_rdata);
      check("vec_mem_we_clear", bus.mem_we, 1'b0);
    end

    // Early drop: core 3 drops req right after its grant. Cores 0 and 1
    // request meanwhile, so core 0 follows core 3 in round-robin order.
    drive(3, 1'b0, 8'h33, '0);
    push_exp(3, 1'b0, 8'h33, '0);
    tick();
    bus.req[3] = 1'b0;
    drive(0, 1'b0, 8'h40, '0);
    drive(1, 1'b1, 8'h41, 32'h4141_4141);
    push_exp(0, 1'b0, 8'h40, '0);
    push_exp(1, 1'b1, 8'h41, 32'h4141_4141);
    finish_txn(3, 1'b0);
    tick();
    bus.req[0] = 1'b0;
    finish_txn(0, 1'b0);
    tick();
    finish_txn(1, 1'b0);
    check("write_keeps_rdata", bus.rdata, {24'hA5A5A5, 8'h40});

    // Reset during the latency countdown: no done, and core 0 wins after.
    drive(2, 1'b0, 8'h50, '0);
    tick();
    check("abort_gnt", bus.gnt, onehot(2));
    tick();
    check("abort_pre_done", bus.done, '0);
    rst = 1'b1;
    drive(0, 1'b0, 8'h51, '0);
    tick();
    check("abort_gnt_clear", bus.gnt, '0);
    check("abort_no_done", bus.done, '0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_mem_en", bus.mem_en, 1'b0);
    rst = 1'b0;
    push_exp(0, 1'b0, 8'h51, '0);
    push_exp(2, 1'b0, 8'h50, '0);
    tick();
    finish_txn(0, 1'b0);
    tick();
    finish_txn(2, 1'b0);

    tick();
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
